// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and default vector bytes for the 6502 interrupt front end.
package interrupt_types;

  // Kind of request presented to control_unit.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RESET = 2'd1,
    NMI   = 2'd2,
    IRQ   = 2'd3
  } intr_type_t;

  // Sequencer state: the reset request must be taken before normal arbitration.
  typedef enum logic {
    RST_REQ = 1'b0,
    RUN     = 1'b1
  } intr_state_t;

  localparam logic [7:0] DEF_VECTOR_HIGH      = 8'hFF;
  localparam logic [7:0] DEF_NMI_VECTOR_LOW   = 8'hFA;
  localparam logic [7:0] DEF_RESET_VECTOR_LOW = 8'hFC;
  localparam logic [7:0] DEF_IRQ_VECTOR_LOW   = 8'hFE;

endpackage

// File: rtl/interrupt_sequencer_sync_chain.sv
// Multi-bit flop synchroniser; resets to all ones, the inactive level of the
// active-low interrupt lines.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the asynchronous input through STAGES flops.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      stage_q <= '1;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt front end: synchronises NMI/IRQ lines, edge-detects NMI, arbitrates
// reset > NMI > IRQ and hands one vectored request to control_unit.
//
// Handshake: request_valid/request_type/vector_address describe the current
// request; a request is taken on a clk_in edge where service_ack=1 and
// request_valid=1. service_ack with request_valid=0 is ignored. service_done
// marks a handler return and lowers the nesting depth.
module interrupt_sequencer
  import interrupt_types::*;
#(
  parameter int         NUM_IRQ          = 4,
  parameter int         SYNC_STAGES      = 2,
  parameter int         MAX_NEST         = 3,
  parameter logic [7:0] VECTOR_HIGH      = DEF_VECTOR_HIGH,
  parameter logic [7:0] NMI_VECTOR_LOW   = DEF_NMI_VECTOR_LOW,
  parameter logic [7:0] RESET_VECTOR_LOW = DEF_RESET_VECTOR_LOW,
  parameter logic [7:0] IRQ_VECTOR_LOW   = DEF_IRQ_VECTOR_LOW,
  localparam int        IRQ_ID_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int        NEST_W           = $clog2(MAX_NEST + 1)
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                nmib,
  input  logic [NUM_IRQ-1:0]  irqb,
  input  logic [NUM_IRQ-1:0]  mask_in,
  input  logic                mask_load,
  input  logic                flag_interrupt_disable,
  input  logic                service_ack,
  input  logic                service_done,
  output logic                request_valid,
  output intr_type_t          request_type,
  output logic [15:0]         vector_address,
  output logic [IRQ_ID_W-1:0] irq_source_id,
  output logic [7:0]          cause_out,
  output logic [NEST_W-1:0]   nest_count,
  output intr_state_t         state_dbg
);

  logic                nmib_sync;
  logic [NUM_IRQ-1:0]  irqb_sync;
  intr_state_t         state_q, state_d;
  logic                nmi_prev_q;
  logic                nmi_pending_q, nmi_pending_d;
  logic [NUM_IRQ-1:0]  mask_q;
  logic [NEST_W-1:0]   nest_q, nest_d;
  logic [NUM_IRQ-1:0]  irq_active;
  logic                nmi_edge;
  logic                nest_room;
  logic                req_valid;
  intr_type_t          req_type;
  logic                ack_take;
  logic [IRQ_ID_W-1:0] low_id;

  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (nmib),
    .q      (nmib_sync)
  );

  sync_chain #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (irqb),
    .q      (irqb_sync)
  );

  assign irq_active = ~irqb_sync & mask_q;
  assign nmi_edge   = nmi_prev_q & ~nmib_sync;
  assign nest_room  = (nest_q < NEST_W'(MAX_NEST));
  assign ack_take   = service_ack & req_valid;

  // Arbitrate the current request from state, pending NMI and active IRQs.
  always_comb begin
    req_valid = 1'b0;
    req_type  = NONE;
    case (state_q)
      RST_REQ: begin
        req_valid = 1'b1;
        req_type  = RESET;
      end
      RUN: begin
        if (nmi_pending_q && nest_room) begin
          req_valid = 1'b1;
          req_type  = NMI;
        end else if ((|irq_active) && !flag_interrupt_disable && nest_room) begin
          req_valid = 1'b1;
          req_type  = IRQ;
        end
      end
      default: ;
    endcase
  end

  // Lowest-index active enabled IRQ line.
  always_comb begin
    low_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_active[i]) low_id = IRQ_ID_W'(i);
    end
  end

  // Next state, nesting depth and NMI pending bit; a fresh NMI edge beats an ack.
  always_comb begin
    state_d       = state_q;
    nest_d        = nest_q;
    nmi_pending_d = nmi_pending_q;
    if (state_q == RST_REQ) begin
      if (ack_take) state_d = RUN;
    end else begin
      if (ack_take && service_done) begin
        nest_d = nest_q;
      end else if (ack_take) begin
        nest_d = nest_q + NEST_W'(1);
      end else if (service_done && (nest_q != '0)) begin
        nest_d = nest_q - NEST_W'(1);
      end
    end
    if (nmi_edge) begin
      nmi_pending_d = 1'b1;
    end else if (ack_take && (req_type == NMI)) begin
      nmi_pending_d = 1'b0;
    end
  end

  // State, pending, mask and depth registers.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q       <= RST_REQ;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      mask_q        <= '1;
      nest_q        <= '0;
    end else begin
      state_q       <= state_d;
      nmi_prev_q    <= nmib_sync;
      nmi_pending_q <= nmi_pending_d;
      nest_q        <= nest_d;
      if (mask_load) mask_q <= mask_in;
    end
  end

  // Drive outputs; while reset is low they show the fixed reset values.
  always_comb begin
    request_valid  = 1'b0;
    request_type   = NONE;
    vector_address = {VECTOR_HIGH, RESET_VECTOR_LOW};
    irq_source_id  = '0;
    cause_out      = 8'h00;
    if (reset) begin
      request_valid = req_valid;
      request_type  = req_type;
      case (req_type)
        NMI:     vector_address = {VECTOR_HIGH, NMI_VECTOR_LOW};
        IRQ:     vector_address = {VECTOR_HIGH, IRQ_VECTOR_LOW};
        default: vector_address = {VECTOR_HIGH, RESET_VECTOR_LOW};
      endcase
      if (req_type == IRQ) irq_source_id = low_id;
      cause_out = (8'(nest_q) << 6) | (8'(nmi_pending_q) << 5) | (8'(irq_active) & 8'h1F);
    end
  end

  assign nest_count = nest_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: a vector table for the main
// behaviour plus hand-written sequences for multi-cycle corner cases.
module tb_interrupt_sequencer;
  import interrupt_types::*;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_RST  = 2'd1;
  localparam logic [1:0] T_NMI  = 2'd2;
  localparam logic [1:0] T_IRQ  = 2'd3;

  // clock / reset block
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       reset, nmib, mask_load, flag_interrupt_disable, service_ack, service_done;
  logic [3:0] irqb, mask_in;

  logic        valid0, valid1;
  logic [1:0]  type0, type1;
  logic [15:0] vec0, vec1;
  logic [1:0]  id0, id1;
  logic [7:0]  cause0, cause1;
  logic [1:0]  nest0;
  logic [0:0]  nest1;
  intr_state_t st0, st1;

  interrupt_sequencer dut0 (
    .clk_in(clk_in), .reset(reset), .nmib(nmib), .irqb(irqb), .mask_in(mask_in),
    .mask_load(mask_load), .flag_interrupt_disable(flag_interrupt_disable),
    .service_ack(service_ack), .service_done(service_done),
    .request_valid(valid0), .request_type(type0), .vector_address(vec0),
    .irq_source_id(id0), .cause_out(cause0), .nest_count(nest0), .state_dbg(st0)
  );

  interrupt_sequencer #(.MAX_NEST(1)) dut1 (
    .clk_in(clk_in), .reset(reset), .nmib(nmib), .irqb(irqb), .mask_in(mask_in),
    .mask_load(mask_load), .flag_interrupt_disable(flag_interrupt_disable),
    .service_ack(service_ack), .service_done(service_done),
    .request_valid(valid1), .request_type(type1), .vector_address(vec1),
    .irq_source_id(id1), .cause_out(cause1), .nest_count(nest1), .state_dbg(st1)
  );

  typedef struct {
    logic        rst_n;
    logic        nmib;
    logic [3:0]  irqb;
    logic [3:0]  mask_in;
    logic        mask_load;
    logic        idis;
    logic        ack;
    logic        done;
    logic        e_valid;
    logic [1:0]  e_type;
    logic [15:0] e_vec;
    logic [1:0]  e_id;
    logic [7:0]  e_cause;
    logic [1:0]  e_nest;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mv(input logic r, input logic n, input logic [3:0] ib,
                              input logic [3:0] mi, input logic ml, input logic id,
                              input logic ak, input logic dn, input logic ev,
                              input logic [1:0] et, input logic [15:0] evec,
                              input logic [1:0] eid, input logic [7:0] ec,
                              input logic [1:0] en);
    vec_t v;
    v.rst_n = r; v.nmib = n; v.irqb = ib; v.mask_in = mi; v.mask_load = ml;
    v.idis = id; v.ack = ak; v.done = dn; v.e_valid = ev; v.e_type = et;
    v.e_vec = evec; v.e_id = eid; v.e_cause = ec; v.e_nest = en;
    return v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic av, input logic [1:0] at,
                     input logic [15:0] avec, input logic [1:0] aid,
                     input logic [7:0] ac, input logic [1:0] an,
                     input logic ev, input logic [1:0] et, input logic [15:0] evec,
                     input logic [1:0] eid, input logic [7:0] ec, input logic [1:0] en);
    n_vec++;
    if (av !== ev || at !== et || avec !== evec || aid !== eid || ac !== ec || an !== en) begin
      n_err++;
      $display("FAIL %s: got valid=%b type=%0d vec=%h id=%0d cause=%h nest=%0d, want valid=%b type=%0d vec=%h id=%0d cause=%h nest=%0d",
               name, av, at, avec, aid, ac, an, ev, et, evec, eid, ec, en);
    end
  endtask

  task automatic chk0(input string name, input logic ev, input logic [1:0] et,
                      input logic [15:0] evec, input logic [1:0] eid,
                      input logic [7:0] ec, input logic [1:0] en);
    chk(name, valid0, type0, vec0, id0, cause0, nest0, ev, et, evec, eid, ec, en);
  endtask

  task automatic chk1(input string name, input logic ev, input logic [1:0] et,
                      input logic [15:0] evec, input logic [1:0] eid,
                      input logic [7:0] ec, input logic [1:0] en);
    chk(name, valid1, type1, vec1, id1, cause1, {1'b0, nest1}, ev, et, evec, eid, ec, en);
  endtask

  initial begin
    reset = 1'b0; nmib = 1'b1; irqb = 4'hF; mask_in = 4'hF; mask_load = 1'b0;
    flag_interrupt_disable = 1'b0; service_ack = 1'b0; service_done = 1'b0;

    //            r  n  irqb  mask ml id ak dn | v  type    vector    id cause  nest
    vecs.push_back(mv(0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(0, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 1, T_RST,  16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 1, T_NMI,  16'hFFFA, 0, 8'h20, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0, T_NONE, 16'hFFFC, 0, 8'h40, 1));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 0, 1, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'hF, 0, 0, 0, 0, 1, T_IRQ,  16'hFFFE, 1, 8'h0A, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'hF, 0, 1, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h0A, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'h8, 1, 0, 0, 0, 1, T_IRQ,  16'hFFFE, 3, 8'h08, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'h0, 1, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'hF, 1, 0, 0, 0, 1, T_IRQ,  16'hFFFE, 1, 8'h0A, 0));
    vecs.push_back(mv(1, 1, 4'h5, 4'hF, 0, 0, 1, 0, 1, T_IRQ,  16'hFFFE, 1, 8'h4A, 1));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 1, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h4A, 1));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 1, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h40, 1));
    vecs.push_back(mv(1, 0, 4'hF, 4'hF, 0, 1, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h40, 1));
    vecs.push_back(mv(1, 0, 4'hF, 4'hF, 0, 1, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h40, 1));
    vecs.push_back(mv(1, 0, 4'hF, 4'hF, 0, 1, 0, 0, 1, T_NMI,  16'hFFFA, 0, 8'h60, 1));
    vecs.push_back(mv(1, 0, 4'hF, 4'hF, 0, 1, 1, 0, 0, T_NONE, 16'hFFFC, 0, 8'h80, 2));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 1, 0, 1, 0, T_NONE, 16'hFFFC, 0, 8'h40, 1));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 1, 0, 1, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 1, 0, 1, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));
    vecs.push_back(mv(1, 1, 4'hF, 4'hF, 0, 0, 0, 0, 0, T_NONE, 16'hFFFC, 0, 8'h00, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst_n; nmib = vecs[i].nmib; irqb = vecs[i].irqb;
      mask_in = vecs[i].mask_in; mask_load = vecs[i].mask_load;
      flag_interrupt_disable = vecs[i].idis; service_ack = vecs[i].ack;
      service_done = vecs[i].done;
      step();
      chk0($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_type, vecs[i].e_vec,
           vecs[i].e_id, vecs[i].e_cause, vecs[i].e_nest);
    end
    mask_in = 4'hF; mask_load = 1'b0; service_ack = 1'b0; service_done = 1'b0;

    // Held-low nmib gives exactly one request.
    nmib = 1'b0;
    step(); step(); step();
    chk0("h1_nmi_req", 1, T_NMI, 16'hFFFA, 0, 8'h20, 0);
    service_ack = 1'b1; step(); service_ack = 1'b0;
    chk0("h1_ack", 0, T_NONE, 16'hFFFC, 0, 8'h40, 1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk0("h1_hold", 0, T_NONE, 16'hFFFC, 0, 8'h40, 1);
    end
    nmib = 1'b1; service_done = 1'b1; step(); service_done = 1'b0;
    chk0("h1_done", 0, T_NONE, 16'hFFFC, 0, 8'h00, 0);
    step(); step(); step();

    // New NMI edge in the same cycle as the NMI ack keeps the request pending.
    nmib = 1'b0; step(); nmib = 1'b1; step(); step();
    chk0("h2_first_req", 1, T_NMI, 16'hFFFA, 0, 8'h20, 0);
    nmib = 1'b0; step();
    chk0("h2_hold_a", 1, T_NMI, 16'hFFFA, 0, 8'h20, 0);
    nmib = 1'b1; step();
    chk0("h2_hold_b", 1, T_NMI, 16'hFFFA, 0, 8'h20, 0);
    service_ack = 1'b1; step(); service_ack = 1'b0;
    chk0("h2_edge_wins", 1, T_NMI, 16'hFFFA, 0, 8'h60, 1);
    step();
    chk0("h2_second_req", 1, T_NMI, 16'hFFFA, 0, 8'h60, 1);
    service_ack = 1'b1; step(); service_ack = 1'b0;
    chk0("h2_second_ack", 0, T_NONE, 16'hFFFC, 0, 8'h80, 2);

    // Reset mid-service discards the pending NMI and the nesting depth.
    nmib = 1'b0; step(); nmib = 1'b1; step(); step();
    chk0("h3_pending", 1, T_NMI, 16'hFFFA, 0, 8'hA0, 2);
    reset = 1'b0; step();
    chk0("h3_in_reset", 0, T_NONE, 16'hFFFC, 0, 8'h00, 0);
    reset = 1'b1; step();
    chk0("h3_rst_req", 1, T_RST, 16'hFFFC, 0, 8'h00, 0);
    service_ack = 1'b1; step(); service_ack = 1'b0;
    chk0("h3_run", 0, T_NONE, 16'hFFFC, 0, 8'h00, 0);

    // MAX_NEST=1: requests held at full depth, NMI still latched.
    irqb = 4'b1110; step(); step();
    chk1("h4_irq", 1, T_IRQ, 16'hFFFE, 0, 8'h01, 0);
    service_ack = 1'b1; step(); service_ack = 1'b0;
    chk1("h4_full", 0, T_NONE, 16'hFFFC, 0, 8'h41, 1);
    irqb = 4'hF; step(); step();
    chk1("h4_irq_gone", 0, T_NONE, 16'hFFFC, 0, 8'h40, 1);
    nmib = 1'b0; step(); nmib = 1'b1; step(); step();
    chk1("h4_nmi_held", 0, T_NONE, 16'hFFFC, 0, 8'h60, 1);
    service_done = 1'b1; step(); service_done = 1'b0;
    chk1("h4_nmi_after_done", 1, T_NMI, 16'hFFFA, 0, 8'h20, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Parametrised interrupt front end for the 6502 core. It replaces the fixed nmib/irqb handling inside control_unit. It synchronises one NMI line and NUM_IRQ maskable IRQ lines, edge-detects NMI, arbitrates reset > NMI > IRQ, and presents one vectored request to control_unit through a valid/ack handshake. It tracks nesting depth so that an NMI can pre-empt an IRQ handler, and exposes a cause register that can drive the data bus.

Parameters:
NUM_IRQ, 4, number of active-low maskable IRQ inputs (1..8)
SYNC_STAGES, 2, synchroniser depth on every external interrupt line (>=1)
MAX_NEST, 3, maximum outstanding serviced interrupts (>=1)
VECTOR_HIGH, 8'hFF, high byte of every vector
NMI_VECTOR_LOW, 8'hFA, low byte of the NMI vector
RESET_VECTOR_LOW, 8'hFC, low byte of the reset vector
IRQ_VECTOR_LOW, 8'hFE, low byte of the IRQ/BRK vector

Ports:
clk_in  in  1  core clock
reset  in  1  synchronous, active-low reset
nmib  in  1  non-maskable interrupt, active-low, asynchronous
irqb  in  NUM_IRQ  maskable interrupt lines, active-low level, asynchronous
mask_in  in  NUM_IRQ  per-line enable value, 1 = enabled
mask_load  in  1  load mask_in into the mask register
flag_interrupt_disable  in  1  I flag from status_register
service_ack  in  1  control_unit accepts the current request (at an instruction boundary)
service_done  in  1  handler returned (RTI executed)
request_valid  out  1  a request is pending
request_type  out  2  intr_type_t: NONE / RESET / NMI / IRQ
vector_address  out  16  {VECTOR_HIGH, low byte selected by request_type}
irq_source_id  out  $clog2(NUM_IRQ) (min 1)  lowest-index active enabled IRQ
cause_out  out  8  {nest_count[1:0], nmi_pending, irq_active_masked[4:0]}, zero-padded
nest_count  out  $clog2(MAX_NEST+1)  current nesting depth

Behaviour:
- Reset (reset==0 at posedge):
  - all synchroniser flops = 1 (inactive); mask = all 1; nmi_pending = 0; nest_count = 0; state = RST_REQ.
  - Outputs while in reset: request_valid=0, request_type=NONE, vector_address={VECTOR_HIGH,RESET_VECTOR_LOW}, irq_source_id=0, cause_out=0.
- Synchroniser: each line passes through SYNC_STAGES flops. irq_active[i] = ~irqb_sync[i] & mask[i].
- NMI edge: a falling edge on the synchronised nmib, i.e. prev=1 and now=0, sets nmi_pending. Latency from an nmib fall to nmi_pending=1 is SYNC_STAGES+1 clk_in edges. A held-low nmib produces only one edge.
- States (intr_state_t):
  - RST_REQ: request_valid=1, type=RESET. On service_ack go to RUN; nest_count is unchanged. No other source is reported in this state.
  - RUN: request selection, highest priority first:
    - NMI when nmi_pending and nest_count<MAX_NEST.
    - IRQ when |irq_active, ~flag_interrupt_disable, and nest_count<MAX_NEST.
    - Otherwise request_valid=0 and type=NONE.
- Outputs are combinational from registered state, pending bits, mask and the synchronised inputs. vector_address and irq_source_id follow request_type in the same cycle.
- service_ack while request_valid=1:
  - nest_count+1.
  - If type=NMI, clear nmi_pending in the same edge.
  - IRQ lines are level-held and are not cleared; the source device deasserts them.
- service_ack while request_valid=0: ignored, with no state change.
- service_done: nest_count-1. When nest_count==0 it is ignored (no underflow).
- Simultaneous events:
  - ack and done in the same cycle: nest_count is unchanged, but ack still clears nmi_pending.
  - NMI edge in the same cycle as an NMI ack: the new edge wins, nmi_pending stays 1 and a second NMI is requested.
- Nesting: an NMI may pre-empt an IRQ handler. At nest_count==MAX_NEST all requests are held pending, and an NMI edge is still latched.
- Mask: mask_load updates mask on the next edge. The new mask affects request_valid one cycle after the load.
- Reset mid-service: everything returns to RST_REQ and pending NMI is discarded.

Decomposition:
- Package interrupt_types holds:
  - intr_type_t (NONE=0, RESET=1, NMI=2, IRQ=3)
  - intr_state_t (RST_REQ, RUN)
  - default vector byte localparams
- Sub-module sync_chain (parameter WIDTH, STAGES): multi-bit flop synchroniser with a synchronous active-low reset value of 1. It is instantiated twice, once for nmib and once for irqb.

Test Plan:
1. Release reset -> cycle 1: request_valid=1, type=RESET, vector_address=16'hFFFC. Pulse ack -> request_valid=0, nest_count=0.
2. Pulse nmib low for 1 cycle, SYNC_STAGES=2 -> request_valid=1 after 3 edges, vector=16'hFFFA. Ack -> nest_count=1, nmi_pending=0. Hold nmib low 20 cycles -> no second request.
3. irqb=4'b0101 (lines 1 and 3 active), mask=4'hF, I=0 -> type=IRQ, irq_source_id=1, vector=16'hFFFE. Set I=1 -> request_valid=0 the same cycle.
4. Ack an IRQ (nest_count=1), then an NMI edge -> NMI requested and acked, nest_count=2. Two service_done -> nest_count=0. A third service_done -> nest_count stays 0.
5. MAX_NEST=1, nest_count=1, NMI edge -> request_valid=0 and cause_out NMI bit=1. service_done -> NMI is requested next cycle.
6. NMI edge arriving in the same cycle as an NMI ack -> nmi_pending remains 1 and a second request_valid follows. Assert reset mid-service -> all outputs return to the reset values.
